// File: rtl/lifo_pop_streamer.sv
// Drain controller for sync_lifo: pops up to burst_len words on request and
// re-times them onto a valid/ready stream via a 2-entry buffer, marking the
// final beat with m_last and pulsing done once the burst has fully drained.
module lifo_pop_streamer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  burst_len,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  popped_cnt,
  output logic                  lifo_read,
  input  logic [DATA_WIDTH-1:0] lifo_data,
  input  logic                  lifo_empty,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);

  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StPop, StDrain, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   remaining_q, remaining_d;
  logic [CNT_WIDTH-1:0]   popped_cnt_q, popped_cnt_d;
  logic                   pending_q, pending_d;

  logic [DATA_WIDTH-1:0]  buf_data_q [2];
  logic                   buf_last_q [2];
  logic                   wr_ptr_q, rd_ptr_q;
  logic [1:0]             occ_q;

  logic                   capture;
  logic                   capture_last;
  logic                   xfer;

  // A pop issued last cycle lands on lifo_data now; empty already shows the post-pop count.
  assign capture      = pending_q;
  assign capture_last = (remaining_q == '0) | lifo_empty;
  assign xfer         = m_valid & m_ready;

  // Pop only when the buffer is guaranteed to have room for the returning word.
  assign lifo_read = (state_q == StPop) & ~lifo_empty & (remaining_q != '0) & ~pending_q &
                     (occ_q <= 2'd1);

  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone);
  assign popped_cnt = popped_cnt_q;
  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = m_valid ? buf_data_q[rd_ptr_q] : '0;
  assign m_last     = m_valid & buf_last_q[rd_ptr_q];

  // Next-state logic for the burst FSM and its counters.
  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    popped_cnt_d = popped_cnt_q;
    pending_d    = pending_q;

    if (lifo_read) begin
      pending_d    = 1'b1;
      remaining_d  = remaining_q - CntOne;
      popped_cnt_d = popped_cnt_q + CntOne;
    end
    if (capture) begin
      pending_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          remaining_d  = burst_len;
          popped_cnt_d = '0;
          state_d      = (burst_len == '0) ? StDone : StPop;
        end
      end
      StPop: begin
        if (capture) begin
          if (capture_last) state_d = StDrain;
        end else if (lifo_empty) begin
          // Ran dry with nothing in flight: burst ends short.
          state_d = StDrain;
        end
      end
      StDrain: begin
        if ((occ_q == 2'd0) && !pending_q) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      remaining_q  <= '0;
      popped_cnt_q <= '0;
      pending_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      popped_cnt_q <= popped_cnt_d;
      pending_q    <= pending_d;
    end
  end

  // 2-entry output FIFO of {data, last}; capture and transfer may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        buf_data_q[i] <= '0;
        buf_last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (capture) begin
        buf_data_q[wr_ptr_q] <= lifo_data;
        buf_last_q[wr_ptr_q] <= capture_last;
        wr_ptr_q             <= ~wr_ptr_q;
      end
      if (xfer) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      if (capture && !xfer) begin
        occ_q <= occ_q + 2'd1;
      end else if (!capture && xfer) begin
        occ_q <= occ_q - 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_lifo_pop_streamer.sv
// Bench for lifo_pop_streamer: a queue-based sync_lifo model feeds the DUT,
// expected beats for each burst are taken straight from the top of that stack.
module tb_lifo_pop_streamer;

  localparam int DW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] burst_len;
  logic          busy;
  logic          done;
  logic [CW-1:0] popped_cnt;
  logic          lifo_read;
  logic [DW-1:0] lifo_data = '0;
  logic          lifo_empty;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;

  always #5 clk = ~clk;

  lifo_pop_streamer #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
    .busy       (busy),
    .done       (done),
    .popped_cnt (popped_cnt),
    .lifo_read  (lifo_read),
    .lifo_data  (lifo_data),
    .lifo_empty (lifo_empty),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready)
  );

  // sync_lifo model: word popped at edge t is on lifo_data during t+1.
  logic [DW-1:0] stack[$];
  int            depth = 0;
  logic          push_en = 1'b0;
  logic [DW-1:0] push_val = '0;
  logic          flush = 1'b0;

  assign lifo_empty = (depth == 0);

  initial begin
    forever begin
      @(posedge clk);
      if (flush) begin
        stack.delete();
      end else begin
        if (lifo_read && stack.size() != 0) lifo_data <= stack.pop_back();
        if (push_en) stack.push_back(push_val);
      end
      depth <= stack.size();
    end
  end

  // Scoreboard
  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            accepted = 0;
  int            rmode    = 0;
  int            rc       = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // m_ready driver: changes just after each rising edge.
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rc++;
      case (rmode)
        1:       m_ready = (rc <= 6) ? 1'b0 : rc[0];
        2:       m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b1;
      endcase
    end
  end

  // Output monitor, sampled on the falling edge.
  initial begin
    bit            stall_prev;
    bit            done_prev;
    logic [DW-1:0] stall_data;
    logic          stall_last;
    beat_t         b;
    stall_prev = 0;
    done_prev  = 0;
    stall_data = '0;
    stall_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall_prev = 0;
        done_prev  = 0;
      end else begin
        if (lifo_read) check("read_while_empty", 32'(lifo_empty), 0);
        if (stall_prev) begin
          check("stall_valid", 32'(m_valid), 1);
          check("stall_data", 32'(m_data), 32'(stall_data));
          check("stall_last", 32'(m_last), 32'(stall_last));
        end
        if (m_valid && m_ready) begin
          check("beat_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            check("beat_data", 32'(m_data), 32'(b.data));
            check("beat_last", 32'(m_last), 32'(b.last));
          end
          accepted++;
        end
        if (done) check("done_single_cycle", 32'(done_prev), 0);
        done_prev  = done;
        stall_prev = m_valid && !m_ready;
        stall_data = m_data;
        stall_last = m_last;
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] v);
    @(negedge clk);
    push_en  = 1'b1;
    push_val = v;
    @(negedge clk);
    push_en  = 1'b0;
  endtask

  task automatic flush_lifo();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  // Expected beats: the top min(len, depth) stack entries, last flag on the final one.
  task automatic load_expected(input logic [CW-1:0] len);
    int    n;
    beat_t b;
    n = (int'(len) < stack.size()) ? int'(len) : stack.size();
    for (int i = 0; i < n; i++) begin
      b.data = stack[stack.size() - 1 - i];
      b.last = (i == n - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic pulse_start(input logic [CW-1:0] len, input int mode);
    @(negedge clk);
    rmode     = mode;
    rc        = 0;
    start     = 1'b1;
    burst_len = len;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_burst(input logic [CW-1:0] len, input int mode, input logic [CW-1:0] exp_cnt);
    bit got_done;
    exp_q.delete();
    load_expected(len);
    pulse_start(len, mode);
    got_done = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (i == 0) check("busy_after_start", 32'(busy), 1);
      if (done) begin
        got_done = 1;
        break;
      end
    end
    check("done_seen", 32'(got_done), 1);
    check("popped_cnt", 32'(popped_cnt), 32'(exp_cnt));
    check("beats_outstanding", 32'(exp_q.size()), 0);
    @(negedge clk);
    check("done_cleared", 32'(done), 0);
    check("busy_cleared", 32'(busy), 0);
    exp_q.delete();
    rmode = 0;
  endtask

  typedef struct {
    int              n;
    logic [4:0][7:0] d;
    logic [CW-1:0]   len;
    int              mode;
    logic [CW-1:0]   exp_cnt;
    logic            exp_empty;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int            np;
    logic [CW-1:0] len;
    logic [CW-1:0] ecnt;
    bit            ok;

    vecs[0] = '{n: 5, d: {8'd10, 8'd26, 8'd38, 8'd32, 8'd31}, len: 4'd5, mode: 0,
                exp_cnt: 4'd5, exp_empty: 1'b1};
    vecs[1] = '{n: 1, d: 40'd11, len: 4'd4, mode: 0, exp_cnt: 4'd1, exp_empty: 1'b1};
    vecs[2] = '{n: 0, d: 40'd0, len: 4'd4, mode: 0, exp_cnt: 4'd0, exp_empty: 1'b1};
    vecs[3] = '{n: 3, d: 40'h0000030201, len: 4'd0, mode: 0, exp_cnt: 4'd0, exp_empty: 1'b0};
    vecs[4] = '{n: 5, d: {8'd10, 8'd26, 8'd38, 8'd32, 8'd31}, len: 4'd5, mode: 1,
                exp_cnt: 4'd5, exp_empty: 1'b1};
    vecs[5] = '{n: 5, d: {8'd10, 8'd26, 8'd38, 8'd32, 8'd31}, len: 4'd15, mode: 2,
                exp_cnt: 4'd5, exp_empty: 1'b1};

    rst       = 1'b1;
    start     = 1'b0;
    burst_len = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_lifo_read", 32'(lifo_read), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_popped_cnt", 32'(popped_cnt), 0);
    check("rst_m_data", 32'(m_data), 0);
    rst = 1'b0;

    // Table-driven bursts
    for (int i = 0; i < 6; i++) begin
      flush_lifo();
      for (int j = 0; j < vecs[i].n; j++) push_word(vecs[i].d[j]);
      run_burst(vecs[i].len, vecs[i].mode, vecs[i].exp_cnt);
      check("lifo_empty_after", 32'(lifo_empty), 32'(vecs[i].exp_empty));
    end

    // Partial burst followed by a second burst draining the rest
    flush_lifo();
    push_word(8'd31); push_word(8'd32); push_word(8'd38); push_word(8'd26); push_word(8'd10);
    run_burst(4'd3, 0, 4'd3);
    run_burst(4'd2, 0, 4'd2);
    check("split_lifo_empty", 32'(lifo_empty), 1);

    // Reset mid-burst after two accepted beats
    flush_lifo();
    push_word(8'd31); push_word(8'd32); push_word(8'd38); push_word(8'd26); push_word(8'd10);
    exp_q.delete();
    load_expected(4'd5);
    accepted = 0;
    pulse_start(4'd5, 0);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (accepted >= 2) begin
        ok = 1;
        break;
      end
    end
    check("two_beats_accepted", 32'(ok), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_m_valid", 32'(m_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    rst = 1'b0;
    exp_q.delete();
    ecnt = CW'(stack.size());
    run_burst(4'd15, 0, ecnt);
    check("post_rst_lifo_empty", 32'(lifo_empty), 1);

    // Randomized bursts against the stack model
    for (int t = 0; t < 20; t++) begin
      flush_lifo();
      np = $urandom_range(0, 8);
      for (int j = 0; j < np; j++) push_word(8'($urandom_range(0, 255)));
      len  = CW'($urandom_range(0, 15));
      ecnt = (int'(len) < np) ? len : CW'(np);
      run_burst(len, 2, ecnt);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
